fe_fetch_queue: RTL and testbench

Parametrised successor of the single-latch fetch stage. It generates the PC, reads the instruction word from I-MEM combinationally, and buffers fetched instructions in a FQ_DEPTH-entry circular fetch queue, so a decode stall no longer freezes fetch immediately. Branch mispredictions from AGEX flush the queue and redirect the PC. An optional direct-mapped BTB (compile-time) provides next-PC prediction. Sits between I-MEM and DE; DE consumes entries through a valid/ready handshake.

---
 rtl/fe_fetch_queue.sv | 152 +++++++++++++++
 tb/tb_fe_fetch_queue.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fe_fetch_queue.sv
// Fetch stage: PC generation, combinational I-MEM read, FQ_DEPTH-entry circular fetch queue.
// Latency: word fetched in cycle N is on out_* in cycle N+1; redirect reaches out_* two cycles after br_mispred.
// Backpressure: fetch continues until the queue is full, then resumes on a pop (push+pop same cycle when full).
// Optional: define FE_BTB_EN for a direct-mapped BTB providing next-PC prediction.
module fe_fetch_queue #(
  parameter int               DBITS       = 32,
  parameter int               INSTBITS    = 32,
  parameter int               INSTSIZE    = 4,
  parameter logic [DBITS-1:0] STARTPC     = '0,
  parameter int               FQ_DEPTH    = 4,
  parameter int               BTB_ENTRIES = 16
) (
  input  logic                clk,
  input  logic                reset,
  output logic [DBITS-1:0]    imem_addr,
  input  logic [INSTBITS-1:0] imem_rdata,
  input  logic                br_mispred,
  input  logic [DBITS-1:0]    br_target,
  input  logic                br_upd_valid,
  input  logic [DBITS-1:0]    br_upd_pc,
  input  logic                br_upd_taken,
  input  logic [DBITS-1:0]    br_upd_target,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INSTBITS-1:0] out_inst,
  output logic [DBITS-1:0]    out_pc,
  output logic [DBITS-1:0]    out_pcplus,
  output logic                out_pred_taken,
  output logic [DBITS-1:0]    out_pred_target
);

  localparam int QW = $clog2(FQ_DEPTH);
  localparam int CW = QW + 1;
  localparam logic [CW-1:0] FULL = CW'(FQ_DEPTH);

  logic [DBITS-1:0]    r_pc;
  logic [QW-1:0]       r_head;
  logic [QW-1:0]       r_tail;
  logic [CW-1:0]       r_count;

  logic [INSTBITS-1:0] r_q_inst   [FQ_DEPTH];
  logic [DBITS-1:0]    r_q_pc     [FQ_DEPTH];
  logic [DBITS-1:0]    r_q_pcplus [FQ_DEPTH];
  logic                r_q_ptaken [FQ_DEPTH];
  logic [DBITS-1:0]    r_q_ptgt   [FQ_DEPTH];

  logic                w_pop;
  logic                w_fire;
  logic                w_push;
  logic                w_pred_taken;
  logic [DBITS-1:0]    w_pred_target;
  logic [DBITS-1:0]    w_pcplus;
  logic [DBITS-1:0]    w_next_pc;

  assign imem_addr = r_pc;
  assign w_pcplus  = r_pc + DBITS'(INSTSIZE);
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid & out_ready;
  // A full queue may still fetch when the head leaves in the same cycle.
  assign w_fire    = (r_count != FULL) | w_pop;
  // An all-zero word is treated as invalid: dropped, but the PC still advances.
  assign w_push    = w_fire & (imem_rdata != '0);
  assign w_next_pc = w_pred_taken ? w_pred_target : w_pcplus;

`ifdef FE_BTB_EN
  localparam int IW = $clog2(BTB_ENTRIES);
  localparam int TW = DBITS - IW - 2;

  logic [BTB_ENTRIES-1:0] r_btb_vld;
  logic [TW-1:0]          r_btb_tag [BTB_ENTRIES];
  logic [DBITS-1:0]       r_btb_tgt [BTB_ENTRIES];

  logic [IW-1:0]          w_rd_idx;
  logic [TW-1:0]          w_rd_tag;
  logic [IW-1:0]          w_wr_idx;
  logic [TW-1:0]          w_wr_tag;
  logic                   w_unused_btb;

  assign w_rd_idx      = r_pc[IW+1:2];
  assign w_rd_tag      = r_pc[DBITS-1:IW+2];
  assign w_wr_idx      = br_upd_pc[IW+1:2];
  assign w_wr_tag      = br_upd_pc[DBITS-1:IW+2];
  assign w_unused_btb  = ^br_upd_pc[1:0];
  assign w_pred_taken  = r_btb_vld[w_rd_idx] && (r_btb_tag[w_rd_idx] == w_rd_tag);
  assign w_pred_target = w_pred_taken ? r_btb_tgt[w_rd_idx] : w_pcplus;

  // BTB valid bits: set on taken update, cleared on not-taken update that hits the tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_btb_vld <= '0;
    end else if (br_upd_valid) begin
      if (br_upd_taken) begin
        r_btb_vld[w_wr_idx] <= 1'b1;
      end else if (r_btb_vld[w_wr_idx] && (r_btb_tag[w_wr_idx] == w_wr_tag)) begin
        r_btb_vld[w_wr_idx] <= 1'b0;
      end
    end
  end

  // BTB tag/target payload; qualified by the valid bits, so no reset needed.
  always_ff @(posedge clk) begin
    if (br_upd_valid && br_upd_taken) begin
      r_btb_tag[w_wr_idx] <= w_wr_tag;
      r_btb_tgt[w_wr_idx] <= br_upd_target;
    end
  end
`else
  logic w_unused_btb;

  assign w_unused_btb  = ^{br_upd_valid, br_upd_pc, br_upd_taken, br_upd_target};
  assign w_pred_taken  = 1'b0;
  assign w_pred_target = w_pcplus;
`endif

  // PC and queue pointers: reset beats redirect, redirect beats normal push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= STARTPC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (br_mispred) begin
      r_pc    <= br_target;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_fire) r_pc   <= w_next_pc;
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Queue payload; occupancy is tracked by r_count so entries need no reset.
  always_ff @(posedge clk) begin
    if (w_push && !reset && !br_mispred) begin
      r_q_inst[r_tail]   <= imem_rdata;
      r_q_pc[r_tail]     <= r_pc;
      r_q_pcplus[r_tail] <= w_pcplus;
      r_q_ptaken[r_tail] <= w_pred_taken;
      r_q_ptgt[r_tail]   <= w_pred_target;
    end
  end

  assign out_inst        = r_q_inst[r_head];
  assign out_pc          = r_q_pc[r_head];
  assign out_pcplus      = r_q_pcplus[r_head];
  assign out_pred_taken  = r_q_ptaken[r_head];
  assign out_pred_target = r_q_ptgt[r_head];

endmodule

// File: tb/tb_fe_fetch_queue.sv
// Bench for fe_fetch_queue: streaming, stall/saturation, redirect, dropped zero words, BTB, mid-stream reset.
// Inputs driven and outputs sampled on the falling edge; expected heads queued in a scoreboard.
// Define FE_BTB_EN for both RTL and bench to exercise the predictor.
module tb_fe_fetch_queue;

  logic        clk = 1'b0;
  logic        reset, br_mispred, br_upd_valid, br_upd_taken, out_ready;
  logic [31:0] br_target, br_upd_pc, br_upd_target;
  logic [31:0] imem_addr, imem_rdata;
  logic        out_valid, out_pred_taken;
  logic [31:0] out_inst, out_pc, out_pcplus, out_pred_target;
  logic        zero_en;
  logic [31:0] zero_addr;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {8'hC3, a[23:0]};
  endfunction

  assign imem_rdata = (zero_en && (imem_addr == zero_addr)) ? 32'h0 : mem_word(imem_addr);

  fe_fetch_queue dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .br_mispred(br_mispred), .br_target(br_target),
    .br_upd_valid(br_upd_valid), .br_upd_pc(br_upd_pc),
    .br_upd_taken(br_upd_taken), .br_upd_target(br_upd_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_pcplus(out_pcplus),
    .out_pred_taken(out_pred_taken), .out_pred_target(out_pred_target)
  );

  task automatic push_exp(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    exp_t e;
    e.pc = pc; e.pt = pt; e.tgt = tgt;
    exp_q.push_back(e);
  endtask

  task automatic push_seq(input logic [31:0] first, input int n);
    for (int k = 0; k < n; k++) push_exp(first + 32'(4 * k), 1'b0, first + 32'(4 * k) + 32'd4);
  endtask

  // Holds reset for two cycles; returns on a falling edge with reset released.
  task automatic do_reset(input logic rdy);
    reset = 1'b1; out_ready = rdy; br_mispred = 1'b0; br_upd_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    exp_t e;
    reset = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({out_valid, imem_addr} !== {1'b0, 32'h0}) begin
      n_miss++; $display("FAIL reset_state: valid=%b addr=%h, required valid=0 addr=00000000", out_valid, imem_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    e.pc = 32'h0;
    n_vec++;
    if ({out_valid, out_pc, out_pcplus, out_pred_taken} !== {1'b1, e.pc, e.pc + 32'd4, 1'b0}) begin
      n_miss++; $display("FAIL first_fetch: valid=%b pc=%h pcplus=%h pt=%b, required 1 00000000 00000004 0",
                         out_valid, out_pc, out_pcplus, out_pred_taken);
    end
  endtask

  task automatic test_stream;
    exp_t e;
    do_reset(1'b1);
    push_seq(32'h0, 16);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1) begin
        n_miss++; $display("FAIL stream_gap: out_valid=%b at cycle %0d, required 1", out_valid, i);
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if ({out_pc, out_pcplus, out_inst, out_pred_taken, out_pred_target} !== {e.pc, e.pc + 32'd4, mem_word(e.pc), e.pt, e.tgt}) begin
          n_miss++; $display("FAIL stream_head: pc=%h pcplus=%h inst=%h pt=%b tgt=%h, required pc=%h pt=%b tgt=%h",
                             out_pc, out_pcplus, out_inst, out_pred_taken, out_pred_target, e.pc, e.pt, e.tgt);
        end
      end
    end
  endtask

  task automatic test_stall;
    exp_t e;
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) @(negedge clk);
    n_vec++;
    if ({out_valid, out_pc, imem_addr} !== {1'b1, 32'h0, 32'h10}) begin
      n_miss++; $display("FAIL stall_hold: valid=%b pc=%h addr=%h, required 1 00000000 00000010", out_valid, out_pc, imem_addr);
    end
    push_seq(32'h0, 5);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (out_valid !== 1'b1) begin
        n_miss++; $display("FAIL stall_release_gap: out_valid=%b at cycle %0d, required 1", out_valid, i);
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if ({out_pc, out_pcplus, out_inst} !== {e.pc, e.pc + 32'd4, mem_word(e.pc)}) begin
          n_miss++; $display("FAIL stall_release_head: pc=%h pcplus=%h inst=%h, required pc=%h", out_pc, out_pcplus, out_inst, e.pc);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mispred;
    exp_t e;
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) @(negedge clk);
    out_ready = 1'b1; br_mispred = 1'b1; br_target = 32'h100;
    @(negedge clk);
    br_mispred = 1'b0; out_ready = 1'b0;
    n_vec++;
    if ({out_valid, imem_addr} !== {1'b0, 32'h100}) begin
      n_miss++; $display("FAIL flush_full_ready: valid=%b addr=%h, required valid=0 addr=00000100", out_valid, imem_addr);
    end
    push_seq(32'h100, 3);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1) begin
        n_miss++; $display("FAIL redirect_gap: out_valid=%b at cycle %0d, required 1", out_valid, i);
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if ({out_pc, out_inst} !== {e.pc, mem_word(e.pc)}) begin
          n_miss++; $display("FAIL redirect_head: pc=%h inst=%h, required pc=%h", out_pc, out_inst, e.pc);
        end
      end
    end
    // Refill to full with DE stalled, then redirect without any pop.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
    br_mispred = 1'b1; br_target = 32'h200;
    @(negedge clk);
    br_mispred = 1'b0;
    n_vec++;
    if ({out_valid, imem_addr} !== {1'b0, 32'h200}) begin
      n_miss++; $display("FAIL flush_full_stalled: valid=%b addr=%h, required valid=0 addr=00000200", out_valid, imem_addr);
    end
  endtask

  task automatic test_zero_word;
    exp_t e;
    zero_en = 1'b1; zero_addr = 32'h8;
    do_reset(1'b1);
    push_exp(32'h0, 1'b0, 32'h4);
    push_exp(32'h4, 1'b0, 32'h8);
    push_seq(32'hC, 3);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++; $display("FAIL zero_extra: pc=%h, required no further entry", out_pc);
        end else begin
          e = exp_q.pop_front();
          if ({out_pc, out_inst} !== {e.pc, mem_word(e.pc)}) begin
            n_miss++; $display("FAIL zero_skip: pc=%h inst=%h, required pc=%h", out_pc, out_inst, e.pc);
          end
        end
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++; $display("FAIL zero_drain: %0d entries missing, required 0", exp_q.size());
    end
    zero_en = 1'b0;
  endtask

`ifdef FE_BTB_EN
  task automatic test_btb;
    exp_t e;
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) @(negedge clk);
    br_upd_valid = 1'b1; br_upd_pc = 32'h20; br_upd_taken = 1'b1; br_upd_target = 32'h80;
    @(negedge clk);
    br_upd_valid = 1'b0;
    push_seq(32'h0, 8);
    push_exp(32'h20, 1'b1, 32'h80);
    push_seq(32'h80, 2);
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
        n_miss++; $display("FAIL btb_gap: out_valid=%b at cycle %0d, required 1", out_valid, i);
      end else begin
        e = exp_q.pop_front();
        if ({out_pc, out_pred_taken, out_pred_target} !== {e.pc, e.pt, e.tgt}) begin
          n_miss++; $display("FAIL btb_taken: pc=%h pt=%b tgt=%h, required pc=%h pt=%b tgt=%h",
                             out_pc, out_pred_taken, out_pred_target, e.pc, e.pt, e.tgt);
        end
      end
      @(negedge clk);
    end
    // Not-taken update together with a redirect to the same PC: both take effect.
    out_ready = 1'b0;
    br_mispred = 1'b1; br_target = 32'h20;
    br_upd_valid = 1'b1; br_upd_pc = 32'h20; br_upd_taken = 1'b0;
    @(negedge clk);
    br_mispred = 1'b0; br_upd_valid = 1'b0;
    n_vec++;
    if ({out_valid, imem_addr} !== {1'b0, 32'h20}) begin
      n_miss++; $display("FAIL btb_redirect: valid=%b addr=%h, required valid=0 addr=00000020", out_valid, imem_addr);
    end
    exp_q.delete();
    push_seq(32'h20, 3);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
        n_miss++; $display("FAIL btb_clear_gap: out_valid=%b at cycle %0d, required 1", out_valid, i);
      end else begin
        e = exp_q.pop_front();
        if ({out_pc, out_pred_taken, out_pred_target} !== {e.pc, e.pt, e.tgt}) begin
          n_miss++; $display("FAIL btb_not_taken: pc=%h pt=%b tgt=%h, required pc=%h pt=%b tgt=%h",
                             out_pc, out_pred_taken, out_pred_target, e.pc, e.pt, e.tgt);
        end
      end
    end
  endtask
`endif

  task automatic test_reset_midstream;
    exp_t e;
    do_reset(1'b0);
    br_upd_valid = 1'b1; br_upd_pc = 32'h4; br_upd_taken = 1'b1; br_upd_target = 32'h40;
    @(negedge clk);
    br_upd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({out_valid, imem_addr} !== {1'b0, 32'h0}) begin
      n_miss++; $display("FAIL midstream_reset: valid=%b addr=%h, required valid=0 addr=00000000", out_valid, imem_addr);
    end
    reset = 1'b0; out_ready = 1'b1;
    exp_q.delete();
    push_seq(32'h0, 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || exp_q.size() == 0) begin
        n_miss++; $display("FAIL post_reset_gap: out_valid=%b at cycle %0d, required 1", out_valid, i);
      end else begin
        e = exp_q.pop_front();
        if ({out_pc, out_pred_taken, out_pred_target} !== {e.pc, e.pt, e.tgt}) begin
          n_miss++; $display("FAIL post_reset_head: pc=%h pt=%b tgt=%h, required pc=%h pt=%b tgt=%h",
                             out_pc, out_pred_taken, out_pred_target, e.pc, e.pt, e.tgt);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b0; br_mispred = 1'b0; br_target = 32'h0;
    br_upd_valid = 1'b0; br_upd_pc = 32'h0; br_upd_taken = 1'b0; br_upd_target = 32'h0;
    zero_en = 1'b0; zero_addr = 32'h0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_mispred();
    test_zero_word();
`ifdef FE_BTB_EN
    test_btb();
`endif
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
